// File: rtl/mantenimiento_pkg.sv
// mantenimiento_pkg: state encoding shared by the maintenance sequencer and the status block.
package mantenimiento_pkg;
    typedef enum logic [2:0] {
        ESPERA        = 3'd0,
        INICIAR       = 3'd1,
        MANTENIMIENTO = 3'd2,
        FINALIZAR     = 3'd3,
        FALLA         = 3'd4
    } estados_t;

    localparam logic [2:0] ST_ESPERA  = ESPERA;
    localparam logic [2:0] ST_INICIAR = INICIAR;
    localparam logic [2:0] ST_MANT    = MANTENIMIENTO;
    localparam logic [2:0] ST_FIN     = FINALIZAR;
    localparam logic [2:0] ST_FALLA   = FALLA;
endpackage

// File: rtl/mantenimiento_multi_fsm_arbitro_rr.sv
// arbitro_rr: combinational round-robin pick of the first request at or above ptr.
module arbitro_rr #(
    parameter int NUM_CH = 4,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);
    int idx;

    // Scan from the farthest offset down so the nearest request at or after ptr wins.
    always_comb begin
        grant_idx = '0;
        grant_valid = 1'b0;
        idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx]) begin
                grant_idx = CH_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mantenimiento_multi_fsm.sv
// mantenimiento_multi_fsm: round-robin multi-channel maintenance sequencer with
// timeout, saturating per-channel session counters and session duration capture.
module mantenimiento_multi_fsm
    import mantenimiento_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DUR_W   = 16,
    parameter int TIMEOUT = 1000,
    localparam int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       iniciar,
    input  logic                    detener,
    output logic [2:0]              estado,
    output logic [CH_W-1:0]         canal,
    output logic                    ocupado,
    output logic [DUR_W-1:0]        duracion,
    output logic                    terminado,
    output logic                    error,
    output logic [NUM_CH*CNT_W-1:0] num_mantenimientos,
    output logic [CNT_W-1:0]        num_errores
);
    localparam logic [DUR_W-1:0] TO_M1 = DUR_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [2:0]                     state_q, state_d;
    logic [CH_W-1:0]                canal_q, canal_d, ptr_q, ptr_d;
    logic [DUR_W-1:0]               dur_q, dur_d, duracion_q, duracion_d, dur_inc;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]               err_q, err_d;
    logic [CH_W-1:0]                grant_idx;
    logic                           grant_valid;

    arbitro_rr #(.NUM_CH(NUM_CH)) u_arb (
        .req        (iniciar),
        .ptr        (ptr_q),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign dur_inc = &dur_q ? dur_q : dur_q + 1'b1;

    // Unlisted state codes fall through to the ESPERA default.
    always_comb begin
        state_d = ST_ESPERA;
        canal_d = canal_q;
        ptr_d = ptr_q;
        dur_d = dur_q;
        duracion_d = duracion_q;
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            ST_ESPERA: begin
                state_d = grant_valid ? ST_INICIAR : ST_ESPERA;
                canal_d = grant_valid ? grant_idx : canal_q;
                ptr_d = !grant_valid ? ptr_q : (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            ST_INICIAR: begin
                state_d = ST_MANT;
                dur_d = '0;
            end
            ST_MANT: begin
                dur_d = dur_inc;
                duracion_d = detener ? dur_inc : duracion_q;
                state_d = detener ? ST_FIN : (TIMEOUT != 0 && dur_q == TO_M1) ? ST_FALLA : ST_MANT;
            end
            ST_FIN: cnt_d[canal_q] = &cnt_q[canal_q] ? cnt_q[canal_q] : cnt_q[canal_q] + 1'b1;
            ST_FALLA: err_d = &err_q ? err_q : err_q + 1'b1;
            default: state_d = ST_ESPERA;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ESPERA;
            canal_q <= '0;
            ptr_q <= '0;
            dur_q <= '0;
            duracion_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            canal_q <= canal_d;
            ptr_q <= ptr_d;
            dur_q <= dur_d;
            duracion_q <= duracion_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign estado = state_q;
    assign canal = canal_q;
    assign ocupado = state_q != ST_ESPERA;
    assign duracion = duracion_q;
    assign terminado = state_q == ST_FIN;
    assign error = state_q == ST_FALLA;
    assign num_mantenimientos = cnt_q;
    assign num_errores = err_q;
endmodule

// File: doc/mantenimiento_multi_fsm.md
# mantenimiento_multi_fsm

Parametrised multi-channel maintenance sequencer, the successor of the single-channel maintenance FSM. It arbitrates round-robin among `NUM_CH` request lines and runs one maintenance session at a time through ESPERA → INICIAR → MANTENIMIENTO → FINALIZAR. It adds a timeout path to a FALLA state, per-channel saturating session counters, an error counter, and measurement of session duration. It sits between the per-unit request logic and the status/register block.

## Interface
Parameters:
- `NUM_CH`, default 4: number of request channels, ≥1.
- `CNT_W`, default 8: width of each session counter and of the error counter.
- `DUR_W`, default 16: width of the duration counter.
- `TIMEOUT`, default 1000: maximum cycles in MANTENIMIENTO. 0 disables the timeout. Must be < 2^DUR_W.
- `CH_W`, derived: `NUM_CH>1 ? $clog2(NUM_CH) : 1`.

Ports:
- `clk` in 1: clock. One clock domain, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `iniciar` in NUM_CH: level request per channel. Sampled only in ESPERA.
- `detener` in 1: stops the active session. Sampled only in MANTENIMIENTO.
- `estado` out 3: current state code.
- `canal` out CH_W: granted channel. Holds its value until the next grant.
- `ocupado` out 1: high when the state is not ESPERA.
- `duracion` out DUR_W: length of the last successful session, in MANTENIMIENTO cycles.
- `terminado` out 1: one-cycle pulse, high exactly while in FINALIZAR.
- `error` out 1: one-cycle pulse, high exactly while in FALLA.
- `num_mantenimientos` out NUM_CH*CNT_W: per-channel successful-session counts. Channel i occupies bits [i*CNT_W +: CNT_W].
- `num_errores` out CNT_W: count of timeouts, all channels combined.

## Operation
State codes: ESPERA=0, INICIAR=1, MANTENIMIENTO=2, FINALIZAR=3, FALLA=4. Unused codes go to ESPERA.

- **ESPERA**
  - If any `iniciar` bit is high, grant the first requesting index at or above `ptr`, searching cyclically.
  - Register the grant into `canal`, set `ptr <= (grant+1) mod NUM_CH`, and go to INICIAR.
  - With no request, stay in ESPERA.
- **INICIAR**
  - Always lasts one cycle.
  - Clear the internal duration counter `dur` to 0.
  - Go to MANTENIMIENTO.
- **MANTENIMIENTO**
  - Each cycle, `dur` increments, saturating at 2^DUR_W−1.
  - If `detener` is high: set `duracion <= dur+1` (saturating) and go to FINALIZAR.
  - Otherwise, if `TIMEOUT≠0` and `dur == TIMEOUT−1`: go to FALLA.
  - `detener` takes priority over the timeout in the same cycle.
- **FINALIZAR**
  - `terminado` is high.
  - `num_mantenimientos[canal]` increments, saturating at 2^CNT_W−1.
  - Go to ESPERA.
- **FALLA**
  - `error` is high.
  - `num_errores` increments, saturating.
  - `duracion` is unchanged.
  - Go to ESPERA.

General rules:
- `iniciar` is ignored outside ESPERA. `detener` is ignored outside MANTENIMIENTO.
- A request dropped before ESPERA samples it is lost. No request is stored.
- Counters never wrap; they saturate.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release):
  - State goes to ESPERA and `ptr` to 0.
  - Every output is 0: `estado`, `canal`, `ocupado`, `duracion`, `terminado`, `error`, all of `num_mantenimientos`, and `num_errores`.
- Reset mid-session aborts the session. No counter is updated.
- Outputs are registered or decoded directly from the state register. No input-to-output combinational path.
- Latency:
  - Request sampled at edge k → INICIAR in cycle k+1 → MANTENIMIENTO from cycle k+2.
  - `detener` sampled in MANTENIMIENTO cycle m → `terminado` in cycle m+1.
  - Counters and `duracion` are updated by the edge that leaves FINALIZAR/MANTENIMIENTO, so they are visible when ESPERA is re-entered.
- Shortest session: `detener` high in the first MANTENIMIENTO cycle gives `duracion`=1. Grant to `terminado` is 3 cycles.
- Timeout: exactly TIMEOUT cycles are spent in MANTENIMIENTO, then FALLA.
- Back-to-back: at least one ESPERA cycle separates consecutive sessions.
- NUM_CH=1: the arbiter degenerates to a single line and `canal` is always 0.

## Structure
- Package `mantenimiento_pkg`: `estados_t` enum (3-bit, codes above), state code constants, shared with the status block.
- Sub-module `arbitro_rr` #(NUM_CH):
  - Inputs: `req`, `ptr`. Output: `grant_idx` (CH_W) and `grant_valid`. Combinational.
  - The pointer register lives in the parent.
- Parent contains the state register, `dur`, `duracion`, and the counter bank.

## Test plan
- Reset/idle: release `reset_n` with `iniciar`=0 for 10 cycles → all outputs 0, `estado`=0.
- Basic session (NUM_CH=4): `iniciar`=4'b0100 for one cycle, `detener` high in the 3rd MANTENIMIENTO cycle → `canal`=2, `terminado` pulses once, `duracion`=3, `num_mantenimientos[2]`=1, other counters 0.
- Round-robin: `iniciar`=4'b1111 held, `detener` always high → grant order 0,1,2,3,0, with 3 active cycles and 1 ESPERA cycle per session.
- Timeout (TIMEOUT=4): one request, `detener` low → exactly 4 MANTENIMIENTO cycles, then `error` pulse. `num_errores`=1, `duracion` and session counters unchanged. Also assert `detener` in the 4th cycle → FINALIZAR wins.
- Saturation (CNT_W=2): 5 successful sessions on channel 0 → `num_mantenimientos[0]`=3. Four timeouts → `num_errores`=3.
- Reset mid-session: drop `reset_n` in MANTENIMIENTO → immediately `estado`=0 and all counters 0. After release, the next request on channel 3 is granted as channel 3 (`ptr` back at 0).
